// File: rtl/mem_lsu.sv
// ============================================================================
// Module   : mem_lsu
// Brief    : Load/store initiator; splits boundary-crossing accesses into two
//            word-aligned memory cycles and returns extended load data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lsu #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_adrs_rd,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [3:0]        mem_byt_en,
    output logic [ADDR_W-1:0] mem_adrs_wr,
    output logic [31:0]       mem_wr_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] c_MEM_END = (ADDR_W+1)'(MEM_BYTES);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_lo_word;
    logic [31:0]       r_hi_word;

    logic              w_accept;
    logic [3:0]        w_req_nbytes;
    logic [ADDR_W:0]   w_req_end;
    logic              w_req_err;
    logic [2:0]        w_nbytes;
    logic [1:0]        w_off;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_base_hi;
    logic              w_split;
    logic [7:0]        w_mask8;
    logic [63:0]       w_wd64;
    logic [31:0]       w_rd32;
    logic [31:0]       w_ext;

    assign w_accept = req_valid && req_ready;

    // One extra bit on the end address makes address wrap-around read as out of range.
    assign w_req_nbytes = 4'd1 << req_size;
    assign w_req_end    = {1'b0, req_addr} + {{(ADDR_W-3){1'b0}}, w_req_nbytes};
    assign w_req_err    = (req_size == 2'd3) || (w_req_end > c_MEM_END);

    assign w_nbytes  = 3'd1 << r_size;
    assign w_off     = r_addr[1:0];
    assign w_base    = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_base_hi = w_base + ADDR_W'(4);
    assign w_split   = ({1'b0, w_off} + w_nbytes) > 3'd4;

    // Lanes and data for both words at once: low half goes to LO, high half to HI.
    assign w_mask8 = ((8'd1 << w_nbytes) - 8'd1) << w_off;
    assign w_wd64  = {32'd0, r_wdata} << {w_off, 3'b000};
    assign w_rd32  = 32'({r_hi_word, r_lo_word} >> {w_off, 3'b000});

    always_comb begin
        w_ext = w_rd32;
        case (r_size)
            2'd0:    w_ext = r_unsigned ? {24'd0, w_rd32[7:0]}
                                        : {{24{w_rd32[7]}}, w_rd32[7:0]};
            2'd1:    w_ext = r_unsigned ? {16'd0, w_rd32[15:0]}
                                        : {{16{w_rd32[15]}}, w_rd32[15:0]};
            default: w_ext = w_rd32;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = 32'd0;
        rsp_err     = 1'b0;
        mem_adrs_rd = '0;
        mem_adrs_wr = '0;
        mem_wr_en   = 1'b0;
        mem_byt_en  = 4'd0;
        mem_wr_data = 32'd0;
        case (r_state)
            S_IDLE: begin
                // Held low while reset is asserted even though the state is IDLE.
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    w_next = w_req_err ? S_RESP : S_LO;
                end
            end
            S_LO: begin
                mem_adrs_rd = w_base;
                mem_adrs_wr = w_base;
                if (r_we) begin
                    mem_wr_en   = 1'b1;
                    mem_byt_en  = w_mask8[3:0];
                    mem_wr_data = w_wd64[31:0];
                end
                w_next = w_split ? S_HI : S_RESP;
            end
            S_HI: begin
                mem_adrs_rd = w_base_hi;
                mem_adrs_wr = w_base_hi;
                if (r_we) begin
                    mem_wr_en   = 1'b1;
                    mem_byt_en  = w_mask8[7:4];
                    mem_wr_data = w_wd64[63:32];
                end
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                rsp_rdata = (r_we || r_err) ? 32'd0 : w_ext;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_err      <= 1'b0;
            r_lo_word  <= 32'd0;
            r_hi_word  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_err      <= w_req_err;
                r_lo_word  <= 32'd0;
                r_hi_word  <= 32'd0;
            end
            if (r_state == S_LO && !r_we) begin
                r_lo_word <= mem_rd_data;
            end
            if (r_state == S_HI && !r_we) begin
                r_hi_word <= mem_rd_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module   : tb_mem_lsu
// Brief    : Directed self-checking bench for mem_lsu with a byte-array memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_adrs_rd;
    logic [31:0] mem_rd_data;
    logic        mem_wr_en;
    logic [3:0]  mem_byt_en;
    logic [31:0] mem_adrs_wr;
    logic [31:0] mem_wr_data;

    logic [7:0]  mem [0:127];
    logic        mem_clear = 1'b1;
    logic [6:0]  ra;
    logic [6:0]  wa;

    int          total = 0;
    int          bad = 0;
    int          lat;
    logic [31:0] got_data;
    logic        got_err;
    logic        rec_wr_en [0:7];
    logic [3:0]  rec_be    [0:7];
    logic [31:0] rec_aw    [0:7];
    logic [31:0] rec_ar    [0:7];
    logic [31:0] rec_wd    [0:7];

    always #5 clk = ~clk;

    mem_lsu #(.MEM_BYTES(128), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_adrs_rd(mem_adrs_rd),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_byt_en(mem_byt_en),
        .mem_adrs_wr(mem_adrs_wr), .mem_wr_data(mem_wr_data)
    );

    assign ra = mem_adrs_rd[6:0];
    assign wa = mem_adrs_wr[6:0];
    assign mem_rd_data = {mem[ra + 7'd3], mem[ra + 7'd2], mem[ra + 7'd1], mem[ra]};

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_byt_en[b]) mem[wa + 7'(b)] <= mem_wr_data[8*b +: 8];
        end
    end

    // Issues one request and records the memory-side signals of every cycle up to rsp_valid.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 99;
        for (int c = 1; c < 8; c++) begin
            rec_wr_en[c] = mem_wr_en; rec_be[c] = mem_byt_en;
            rec_aw[c] = mem_adrs_wr; rec_ar[c] = mem_adrs_rd; rec_wd[c] = mem_wr_data;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        got_data = rsp_rdata;
        got_err = rsp_err;
    endtask

    task automatic finish_rsp;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        total++; if ({rsp_valid, rsp_err, mem_wr_en, mem_byt_en} !== 7'd0) begin bad++; $display("FAIL reset_ctrl: got %b want 0", {rsp_valid, rsp_err, mem_wr_en, mem_byt_en}); end
        total++; if ({mem_adrs_rd, mem_adrs_wr, mem_wr_data, rsp_rdata} !== 128'd0) begin bad++; $display("FAIL reset_data: got %h want 0", {mem_adrs_rd, mem_adrs_wr, mem_wr_data, rsp_rdata}); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_clear = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_word;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        total++; if (lat !== 2) begin bad++; $display("FAIL wst_latency: got %0d want 2", lat); end
        total++; if ({rec_wr_en[1], rec_be[1], rec_aw[1], rec_wd[1]} !== {1'b1, 4'hF, 32'h10, 32'hDEADBEEF}) begin bad++;
            $display("FAIL wst_lo: got we=%b be=%b a=%h d=%h want 1 1111 10 deadbeef", rec_wr_en[1], rec_be[1], rec_aw[1], rec_wd[1]); end
        total++; if ({got_err, got_data} !== 33'd0) begin bad++; $display("FAIL wst_rsp: got err=%b d=%h want 0 0", got_err, got_data); end
        finish_rsp();
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        total++; if ({rec_wr_en[1], rec_be[1], rec_ar[1]} !== {1'b0, 4'h0, 32'h10}) begin bad++;
            $display("FAIL wld_lo: got we=%b be=%b ar=%h want 0 0000 10", rec_wr_en[1], rec_be[1], rec_ar[1]); end
        total++; if ({lat[3:0], got_err, got_data} !== {4'd2, 1'b0, 32'hDEADBEEF}) begin bad++;
            $display("FAIL wld_rsp: got lat=%0d err=%b d=%h want 2 0 deadbeef", lat, got_err, got_data); end
        finish_rsp();
    endtask

    task automatic test_byte;
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5);
        total++; if ({rec_wr_en[1], rec_be[1], rec_aw[1], rec_wd[1]} !== {1'b1, 4'b1000, 32'h10, 32'hA5000000}) begin bad++;
            $display("FAIL bst_lo: got we=%b be=%b a=%h d=%h want 1 1000 10 a5000000", rec_wr_en[1], rec_be[1], rec_aw[1], rec_wd[1]); end
        finish_rsp();
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        total++; if (got_data !== 32'hFFFFFFA5) begin bad++; $display("FAIL bld_signed: got %h want ffffffa5", got_data); end
        finish_rsp();
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        total++; if (got_data !== 32'h000000A5) begin bad++; $display("FAIL bld_unsigned: got %h want 000000a5", got_data); end
        finish_rsp();
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        total++; if ({lat[3:0], got_data} !== {4'd2, 32'hFFFFA5AD}) begin bad++; $display("FAIL hld_signed: got lat=%0d d=%h want 2 ffffa5ad", lat, got_data); end
        finish_rsp();
    endtask

    task automatic test_misaligned;
        do_req(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344);
        total++; if (lat !== 3) begin bad++; $display("FAIL mst_latency: got %0d want 3", lat); end
        total++; if ({rec_wr_en[1], rec_be[1], rec_aw[1], rec_wd[1]} !== {1'b1, 4'b1100, 32'h0C, 32'h33440000}) begin bad++;
            $display("FAIL mst_lo: got we=%b be=%b a=%h d=%h want 1 1100 0c 33440000", rec_wr_en[1], rec_be[1], rec_aw[1], rec_wd[1]); end
        total++; if ({rec_wr_en[2], rec_be[2], rec_aw[2], rec_wd[2]} !== {1'b1, 4'b0011, 32'h10, 32'h00001122}) begin bad++;
            $display("FAIL mst_hi: got we=%b be=%b a=%h d=%h want 1 0011 10 00001122", rec_wr_en[2], rec_be[2], rec_aw[2], rec_wd[2]); end
        finish_rsp();
        do_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0);
        total++; if ({lat[3:0], got_err, got_data} !== {4'd3, 1'b0, 32'h11223344}) begin bad++;
            $display("FAIL mld_rsp: got lat=%0d err=%b d=%h want 3 0 11223344", lat, got_err, got_data); end
        total++; if ({rec_ar[1], rec_ar[2]} !== {32'h0C, 32'h10}) begin bad++; $display("FAIL mld_addr: got %h %h want 0c 10", rec_ar[1], rec_ar[2]); end
        finish_rsp();
        do_req(1'b0, 2'd1, 1'b0, 32'h0F, 32'h0);
        total++; if ({lat[3:0], got_data} !== {4'd3, 32'h00002233}) begin bad++; $display("FAIL mhld_rsp: got lat=%0d d=%h want 3 00002233", lat, got_data); end
        finish_rsp();
    endtask

    task automatic test_errors;
        do_req(1'b0, 2'd2, 1'b0, 32'h7E, 32'h0);
        total++; if ({lat[3:0], got_err, got_data} !== {4'd1, 1'b1, 32'h0}) begin bad++;
            $display("FAIL err_range: got lat=%0d err=%b d=%h want 1 1 0", lat, got_err, got_data); end
        finish_rsp();
        do_req(1'b1, 2'd2, 1'b0, 32'h7E, 32'hCAFEF00D);
        total++; if ({lat[3:0], got_err, rec_wr_en[1]} !== {4'd1, 1'b1, 1'b0}) begin bad++;
            $display("FAIL err_store: got lat=%0d err=%b we=%b want 1 1 0", lat, got_err, rec_wr_en[1]); end
        finish_rsp();
        do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
        total++; if ({lat[3:0], got_err, got_data} !== {4'd1, 1'b1, 32'h0}) begin bad++;
            $display("FAIL err_size: got lat=%0d err=%b d=%h want 1 1 0", lat, got_err, got_data); end
        finish_rsp();
        do_req(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
        total++; if (got_err !== 1'b1) begin bad++; $display("FAIL err_wrap: got %b want 1", got_err); end
        finish_rsp();
        do_req(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0);
        total++; if ({lat[3:0], got_err} !== {4'd2, 1'b0}) begin bad++; $display("FAIL last_word: got lat=%0d err=%b want 2 0", lat, got_err); end
        finish_rsp();
    endtask

    task automatic test_backpressure;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        total++; if (got_data !== 32'hA5AD1122) begin bad++; $display("FAIL bp_data: got %h want a5ad1122", got_data); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            total++; if ({rsp_valid, rsp_err, req_ready, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hA5AD1122}) begin bad++;
                $display("FAIL bp_hold%0d: got v=%b e=%b rdy=%b d=%h want 1 0 0 a5ad1122", k, rsp_valid, rsp_err, req_ready, rsp_rdata); end
        end
        finish_rsp();
        total++; if ({req_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL bp_release: got rdy=%b v=%b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0E; req_wdata = 32'h55667788;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++; if ({mem_wr_en, mem_byt_en} !== 5'b1_1100) begin bad++; $display("FAIL rmid_lo: got we=%b be=%b want 1 1100", mem_wr_en, mem_byt_en); end
        rst_n = 1'b0;
        #1;
        total++; if ({req_ready, rsp_valid, mem_wr_en, mem_byt_en, mem_adrs_wr, mem_wr_data} !== 71'd0) begin bad++;
            $display("FAIL rmid_outs: got rdy=%b v=%b we=%b be=%b a=%h d=%h want all 0", req_ready, rsp_valid, mem_wr_en, mem_byt_en, mem_adrs_wr, mem_wr_data); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
        total++; if ({mem[16], mem[17], mem[14]} !== 24'h221144) begin bad++;
            $display("FAIL rmid_mem: got %h %h %h want 22 11 44", mem[16], mem[17], mem[14]); end
        do_req(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0);
        total++; if (got_data !== 32'h11223344) begin bad++; $display("FAIL rmid_reload: got %h want 11223344", got_data); end
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_misaligned();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
